// File: rtl/datapath_pkg.sv
// Shared encodings for the pipelined datapath: function-select and shift-select
// codes plus a helper that classifies arithmetic function codes.
package datapath_pkg;

   localparam logic [3:0] FS_A    = 4'b0000;
   localparam logic [3:0] FS_INC  = 4'b0001;
   localparam logic [3:0] FS_ADD  = 4'b0010;
   localparam logic [3:0] FS_ADDC = 4'b0011;
   localparam logic [3:0] FS_ADDN = 4'b0100;
   localparam logic [3:0] FS_SUB  = 4'b0101;
   localparam logic [3:0] FS_DEC  = 4'b0110;
   localparam logic [3:0] FS_A2   = 4'b0111;
   localparam logic [3:0] FS_AND  = 4'b1000;
   localparam logic [3:0] FS_OR   = 4'b1001;
   localparam logic [3:0] FS_XOR  = 4'b1010;
   localparam logic [3:0] FS_NOT  = 4'b1011;
   localparam logic [3:0] FS_B    = 4'b1100;

   localparam logic [2:0] SS_SRL  = 3'b000;
   localparam logic [2:0] SS_SLL  = 3'b001;
   localparam logic [2:0] SS_ROR  = 3'b010;
   localparam logic [2:0] SS_ROL  = 3'b011;
   localparam logic [2:0] SS_SRA  = 3'b100;

   function automatic logic fs_is_arith(input logic [3:0] fs);
      return (fs >= FS_INC) && (fs <= FS_DEC);
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter/rotator applied to the B operand; amount 0 and the
// unused select codes pass the operand through unchanged.
module barrel_shifter
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16,
   localparam int SW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [2:0]       i_ss,
   input  logic [SW-1:0]    i_sa,
   output logic [WIDTH-1:0] o_data
);

   // Rotates index modulo WIDTH by letting the SW-bit index wrap naturally.
   always_comb begin
      o_data = i_data;
      case (i_ss)
         SS_SRL: o_data = i_data >> i_sa;
         SS_SLL: o_data = i_data << i_sa;
         SS_ROR: for (int i = 0; i < WIDTH; i++) o_data[i] = i_data[SW'(i) + i_sa];
         SS_ROL: for (int i = 0; i < WIDTH; i++) o_data[i] = i_data[SW'(i) - i_sa];
         SS_SRA: o_data = $signed(i_data) >>> i_sa;
         default: o_data = i_data;
      endcase
   end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage register-file datapath: S1 reads/forwards operands and shifts B,
// S2 runs the function unit, selects BUSD, writes back and updates the flags.
module pipelined_datapath
   import datapath_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int AW      = 4,
   parameter bit ZERO_R0 = 1'b0,
   localparam int SW     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [AW-1:0]    da,
   input  logic [AW-1:0]    aa,
   input  logic [AW-1:0]    ba,
   input  logic             mb,
   input  logic             md,
   input  logic             rw,
   input  logic [3:0]       fs,
   input  logic [2:0]       ss,
   input  logic [SW-1:0]    sa,
   input  logic [WIDTH-1:0] constant,
   input  logic [WIDTH-1:0] data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             V,
   output logic             C,
   output logic             N,
   output logic             Z
);

   localparam int NREG = 1 << AW;

   logic [WIDTH-1:0] r_regs [NREG];
   logic             r_s2_valid, r_s2_md, r_s2_rw;
   logic [AW-1:0]    r_s2_da;
   logic [3:0]       r_s2_fs;
   logic [WIDTH-1:0] r_s2_a, r_s2_b;
   logic             r_out_valid, r_v, r_c, r_n, r_z;
   logic [WIDTH-1:0] r_result;

   logic             w_hit_a, w_hit_b, w_wr_en, w_arith, w_cin;
   logic [WIDTH-1:0] w_rd_a, w_rd_b, w_a, w_b_reg, w_b_mux, w_b_sh;
   logic [WIDTH-1:0] w_y, w_fu, w_busd;
   logic [WIDTH:0]   w_sum;
   logic             w_c, w_v;

   // S1 operand read with S2 bypass; R0 is never bypassed when hard-wired to zero
   assign w_rd_a  = (ZERO_R0 && (aa == {AW{1'b0}})) ? {WIDTH{1'b0}} : r_regs[aa];
   assign w_rd_b  = (ZERO_R0 && (ba == {AW{1'b0}})) ? {WIDTH{1'b0}} : r_regs[ba];
   assign w_hit_a = r_s2_valid && r_s2_rw && (r_s2_da == aa) && !(ZERO_R0 && (aa == {AW{1'b0}}));
   assign w_hit_b = r_s2_valid && r_s2_rw && (r_s2_da == ba) && !(ZERO_R0 && (ba == {AW{1'b0}}));
   assign w_a     = w_hit_a ? w_busd : w_rd_a;
   assign w_b_reg = w_hit_b ? w_busd : w_rd_b;
   assign w_b_mux = mb ? constant : w_b_reg;

   barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
      .i_data (w_b_mux),
      .i_ss   (ss),
      .i_sa   (sa),
      .o_data (w_b_sh)
   );

   // Second adder operand and carry-in for the arithmetic function codes
   always_comb begin
      w_y   = {WIDTH{1'b0}};
      w_cin = 1'b0;
      case (r_s2_fs)
         FS_INC:  w_cin = 1'b1;
         FS_ADD:  w_y = r_s2_b;
         FS_ADDC: begin w_y = r_s2_b;  w_cin = 1'b1; end
         FS_ADDN: w_y = ~r_s2_b;
         FS_SUB:  begin w_y = ~r_s2_b; w_cin = 1'b1; end
         FS_DEC:  w_y = {WIDTH{1'b1}};
         default: w_y = {WIDTH{1'b0}};
      endcase
   end

   assign w_arith = fs_is_arith(r_s2_fs);
   assign w_sum   = {1'b0, r_s2_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
   assign w_c     = w_arith & w_sum[WIDTH];
   assign w_v     = w_arith & (r_s2_a[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != r_s2_a[WIDTH-1]);

   // Function unit output
   always_comb begin
      w_fu = {WIDTH{1'b0}};
      case (r_s2_fs)
         FS_A, FS_A2: w_fu = r_s2_a;
         FS_INC, FS_ADD, FS_ADDC, FS_ADDN, FS_SUB, FS_DEC: w_fu = w_sum[WIDTH-1:0];
         FS_AND:  w_fu = r_s2_a & r_s2_b;
         FS_OR:   w_fu = r_s2_a | r_s2_b;
         FS_XOR:  w_fu = r_s2_a ^ r_s2_b;
         FS_NOT:  w_fu = ~r_s2_a;
         FS_B:    w_fu = r_s2_b;
         default: w_fu = {WIDTH{1'b0}};
      endcase
   end

   assign w_busd  = r_s2_md ? data : w_fu;
   assign w_wr_en = r_s2_valid && r_s2_rw && !(ZERO_R0 && (r_s2_da == {AW{1'b0}}));

   // S1 -> S2 pipeline capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_md    <= 1'b0;
         r_s2_rw    <= 1'b0;
         r_s2_da    <= {AW{1'b0}};
         r_s2_fs    <= 4'b0000;
         r_s2_a     <= {WIDTH{1'b0}};
         r_s2_b     <= {WIDTH{1'b0}};
      end else begin
         r_s2_valid <= in_valid;
         if (in_valid) begin
            r_s2_md <= md;
            r_s2_rw <= rw;
            r_s2_da <= da;
            r_s2_fs <= fs;
            r_s2_a  <= w_a;
            r_s2_b  <= w_b_sh;
         end
      end
   end

   // Retirement: result, status flags and the one-cycle valid pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= {WIDTH{1'b0}};
         r_v         <= 1'b0;
         r_c         <= 1'b0;
         r_n         <= 1'b0;
         r_z         <= 1'b0;
      end else begin
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_result <= w_busd;
            r_v      <= w_v;
            r_c      <= w_c;
            r_n      <= w_fu[WIDTH-1];
            r_z      <= (w_fu == {WIDTH{1'b0}});
         end
      end
   end

   // Register file writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= {WIDTH{1'b0}};
      end else if (w_wr_en) begin
         r_regs[r_s2_da] <= w_busd;
      end
   end

   assign dbg_data  = (ZERO_R0 && (dbg_addr == {AW{1'b0}})) ? {WIDTH{1'b0}} : r_regs[dbg_addr];
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign V         = r_v;
   assign C         = r_c;
   assign N         = r_n;
   assign Z         = r_z;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: one default instance and one with
// ZERO_R0=1 share all inputs; expected values are hand-computed constants.
module tb_pipelined_datapath;
   import datapath_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, mb, md, rw;
   logic [3:0]  da, aa, ba, fs, sa, dbg_addr;
   logic [2:0]  ss;
   logic [15:0] constant, data;
   logic [15:0] dbg_data, result, dbg_data_z, result_z;
   logic        out_valid, V, C, N, Z, out_valid_z, V_z, C_z, N_z, Z_z;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   pipelined_datapath #(.WIDTH(16), .AW(4), .ZERO_R0(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .da(da), .aa(aa), .ba(ba),
      .mb(mb), .md(md), .rw(rw), .fs(fs), .ss(ss), .sa(sa), .constant(constant),
      .data(data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .out_valid(out_valid),
      .result(result), .V(V), .C(C), .N(N), .Z(Z));

   pipelined_datapath #(.WIDTH(16), .AW(4), .ZERO_R0(1'b1)) u_dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .da(da), .aa(aa), .ba(ba),
      .mb(mb), .md(md), .rw(rw), .fs(fs), .ss(ss), .sa(sa), .constant(constant),
      .data(data), .dbg_addr(dbg_addr), .dbg_data(dbg_data_z), .out_valid(out_valid_z),
      .result(result_z), .V(V_z), .C(C_z), .N(N_z), .Z(Z_z));

   typedef struct {
      logic [3:0]  f;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [15:0] res;
      logic [3:0]  vcnz;
   } op_t;

   typedef struct {
      logic [2:0]  s;
      logic [3:0]  amt;
      logic [15:0] k;
      logic [15:0] res;
   } sh_t;

   // Register contents when the table runs: R1=5, R2=8000, R3=5
   op_t ops [12] = '{
      '{FS_AND,  4'd2, 4'd1, 16'h0000, 4'b0001},
      '{FS_OR,   4'd2, 4'd1, 16'h8005, 4'b0010},
      '{FS_XOR,  4'd2, 4'd3, 16'h8005, 4'b0010},
      '{FS_NOT,  4'd1, 4'd0, 16'hFFFA, 4'b0010},
      '{FS_DEC,  4'd1, 4'd0, 16'h0004, 4'b0100},
      '{4'b1101, 4'd1, 4'd2, 16'h0000, 4'b0001},
      '{FS_A,    4'd2, 4'd0, 16'h8000, 4'b0010},
      '{FS_ADDN, 4'd1, 4'd3, 16'hFFFF, 4'b0010},
      '{FS_ADD,  4'd2, 4'd2, 16'h0000, 4'b1101},
      '{FS_ADDC, 4'd1, 4'd3, 16'h000B, 4'b0000},
      '{FS_A2,   4'd3, 4'd0, 16'h0005, 4'b0000},
      '{4'b1111, 4'd2, 4'd2, 16'h0000, 4'b0001}
   };

   sh_t shs [12] = '{
      '{SS_ROR, 4'd4,  16'h1234, 16'h4123},
      '{SS_SRA, 4'd3,  16'h8000, 16'hF000},
      '{SS_SLL, 4'd15, 16'h0001, 16'h8000},
      '{SS_ROL, 4'd1,  16'h8001, 16'h0003},
      '{SS_SRL, 4'd15, 16'h8000, 16'h0001},
      '{SS_ROR, 4'd0,  16'hBEEF, 16'hBEEF},
      '{SS_SRA, 4'd0,  16'h8000, 16'h8000},
      '{3'b101, 4'd5,  16'h1234, 16'h1234},
      '{SS_SRA, 4'd4,  16'h7FF0, 16'h07FF},
      '{SS_SLL, 4'd4,  16'h1234, 16'h2340},
      '{SS_SRL, 4'd4,  16'h1234, 16'h0123},
      '{SS_ROL, 4'd4,  16'h1234, 16'h2341}
   };

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp_vcnz);
      chk(tag, {12'h000, V, C, N, Z}, {12'h000, exp_vcnz});
   endtask

   task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [3:0] a,
                        input logic [3:0] b, input logic m_b, input logic r_w,
                        input logic [15:0] k, input logic [2:0] s, input logic [3:0] amt);
      in_valid = 1'b1; fs = f; da = d; aa = a; ba = b; mb = m_b; rw = r_w;
      constant = k; ss = s; sa = amt; md = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      rw       = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_state_check(input string tag);
      chk({tag, "_out_valid"}, {15'h0000, out_valid}, 16'h0000);
      chk({tag, "_result"}, result, 16'h0000);
      chk_flags({tag, "_flags"}, 4'b0000);
      chk({tag, "_result_z"}, result_z, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), dbg_data, 16'h0000);
      end
      chk({tag, "_out_valid_after"}, {15'h0000, out_valid}, 16'h0000);
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; mb = 1'b0; md = 1'b0; rw = 1'b0;
      da = 4'd0; aa = 4'd0; ba = 4'd0; fs = 4'd0; sa = 4'd0; ss = 3'd0;
      constant = 16'h0000; data = 16'h0000; dbg_addr = 4'd0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_state_check("rst_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Dependent back-to-back pair through the bypass path
      issue(FS_B, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 16'h7FFF, SS_SRL, 4'd0);
      issue(FS_INC, 4'd2, 4'd1, 4'd0, 1'b0, 1'b1, 16'h0000, SS_SRL, 4'd0);
      chk("fwd_i1_valid", {15'h0000, out_valid}, 16'h0001);
      chk("fwd_i1_result", result, 16'h7FFF);
      chk_flags("fwd_i1_flags", 4'b0000);
      idle();
      chk("fwd_i2_valid", {15'h0000, out_valid}, 16'h0001);
      chk("fwd_i2_result", result, 16'h8000);
      chk_flags("fwd_i2_flags", 4'b1010);
      dbg_addr = 4'd2; #1;
      chk("fwd_r2", dbg_data, 16'h8000);
      dbg_addr = 4'd1; #1;
      chk("fwd_r1", dbg_data, 16'h7FFF);
      idle();
      chk("idle_valid", {15'h0000, out_valid}, 16'h0000);
      chk("idle_result_hold", result, 16'h8000);
      chk_flags("idle_flags_hold", 4'b1010);

      // Subtract equal values, B operand bypassed from the preceding write
      issue(FS_B, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0005, SS_SRL, 4'd0);
      issue(FS_B, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 16'h0005, SS_SRL, 4'd0);
      issue(FS_SUB, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0, 16'h0000, SS_SRL, 4'd0);
      idle();
      chk("sub_result", result, 16'h0000);
      chk_flags("sub_flags", 4'b0101);

      for (int i = 0; i < 12; i++) begin
         issue(ops[i].f, 4'd0, ops[i].a, ops[i].b, 1'b0, 1'b0, 16'h0000, SS_SRL, 4'd0);
         idle();
         chk($sformatf("op%0d_result", i), result, ops[i].res);
         chk_flags($sformatf("op%0d_flags", i), ops[i].vcnz);
      end

      for (int i = 0; i < 12; i++) begin
         issue(FS_B, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, shs[i].k, shs[i].s, shs[i].amt);
         idle();
         chk($sformatf("sh%0d_result", i), result, shs[i].res);
      end

      // D-mux: data is taken in the cycle after issue
      in_valid = 1'b1; fs = FS_B; mb = 1'b1; constant = 16'h0000; da = 4'd4;
      rw = 1'b1; md = 1'b1; ss = SS_SRL; sa = 4'd0; data = 16'h0000;
      @(negedge clk);
      data = 16'h5A5A;
      idle();
      md = 1'b0;
      chk("md_result", result, 16'h5A5A);
      chk_flags("md_flags", 4'b0001);
      dbg_addr = 4'd4; #1;
      chk("md_r4", dbg_data, 16'h5A5A);

      // R0 write, then an immediate and a later read of R0
      issue(FS_B, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 16'hABCD, SS_SRL, 4'd0);
      issue(FS_A, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, SS_SRL, 4'd0);
      chk("r0z_valid", {15'h0000, out_valid_z}, 16'h0001);
      chk("r0z_wr_result", result_z, 16'hABCD);
      dbg_addr = 4'd0; #1;
      chk("r0z_dbg", dbg_data_z, 16'h0000);
      chk("r0_dbg_normal", dbg_data, 16'hABCD);
      idle();
      chk("r0z_fwd_read", result_z, 16'h0000);
      chk("r0z_fwd_flags", {12'h000, V_z, C_z, N_z, Z_z}, 16'h0001);
      chk("r0_fwd_read_normal", result, 16'hABCD);
      issue(FS_A, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, SS_SRL, 4'd0);
      idle();
      chk("r0z_late_read", result_z, 16'h0000);
      chk("r0_late_read_normal", result, 16'hABCD);

      // Reset lands while a write to R5 sits in S2
      issue(FS_B, 4'd5, 4'd0, 4'd0, 1'b1, 1'b1, 16'hABCD, SS_SRL, 4'd0);
      in_valid = 1'b0;
      rw = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_valid_in_rst", {15'h0000, out_valid}, 16'h0000);
      @(negedge clk);
      chk("abort_valid_after_edge", {15'h0000, out_valid}, 16'h0000);
      rst_n = 1'b1;
      reset_state_check("rst_mid");
      @(negedge clk);
      chk("abort_valid_late", {15'h0000, out_valid}, 16'h0000);
      dbg_addr = 4'd5; #1;
      chk("abort_r5", dbg_data, 16'h0000);

      // First instruction issued in the cycle reset is released
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(FS_B, 4'd6, 4'd0, 4'd0, 1'b1, 1'b1, 16'h1111, SS_SRL, 4'd0);
      idle();
      chk("post_rst_valid", {15'h0000, out_valid}, 16'h0001);
      chk("post_rst_result", result, 16'h1111);
      dbg_addr = 4'd6; #1;
      chk("post_rst_r6", dbg_data, 16'h1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
